// File: rtl/lights_reaction_timer.sv
// Start-light reaction timer: measures prescaled ticks from lights-out to trigger.
// Optional best-time register enabled by LIGHTS_BEST_TIME_EN.
module lights_reaction_timer #(
    parameter int TICK_DIV = 1000,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         lights,
    input  logic               trigger,
    output logic [COUNT_W-1:0] time_out,
    output logic               valid,
    output logic               false_start,
    output logic               busy,
    output logic [COUNT_W-1:0] best_time
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] CMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEQ,
        S_FULL,
        S_TIMING,
        S_DONE,
        S_FAULT
    } state_e;

    logic [1:0] rsync_q;
    logic       rst_ni;

    // Assert immediately, release two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsync_q <= '0;
        else        rsync_q <= {rsync_q[0], 1'b1};
    end
    assign rst_ni = rsync_q[1];

    state_e             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] time_q, time_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               fs_q, fs_d;
    logic               tick;
    logic [COUNT_W-1:0] cnt_inc;

    assign tick    = (presc_q == PMAX);
    assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + COUNT_W'(1);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        time_d  = time_q;
        valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (lights != 8'h00)
                    state_d = trigger ? S_FAULT : S_SEQ;
            end
            S_SEQ: begin
                if (trigger)               state_d = S_FAULT;
                else if (lights == 8'hFF)  state_d = S_FULL;
                else if (lights == 8'h00)  state_d = S_IDLE;
            end
            S_FULL: begin
                if (trigger) begin
                    state_d = S_FAULT;
                end else if (lights == 8'h00) begin
                    state_d = S_TIMING;
                    presc_d = '0;
                    cnt_d   = '0;
                end
            end
            S_TIMING: begin
                if (tick) begin
                    presc_d = '0;
                    cnt_d   = cnt_inc;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                // A tick completing on the trigger edge still counts.
                if (trigger) begin
                    time_d  = cnt_d;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else if (lights != 8'h00) begin
                    state_d = S_SEQ;
                end
            end
            S_DONE: begin
                if (!trigger) state_d = S_IDLE;
            end
            S_FAULT: begin
                if (lights == 8'h00 && !trigger) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_SEQ) || (state_d == S_FULL) ||
                 (state_d == S_TIMING);
        fs_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            time_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            time_q  <= time_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fs_q    <= fs_d;
        end
    end

    assign time_out    = time_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign false_start = fs_q;

`ifdef LIGHTS_BEST_TIME_EN
    logic [COUNT_W-1:0] best_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)
            best_q <= '1;
        else if (valid_d && (time_d < best_q))
            best_q <= time_d;
    end
    assign best_time = best_q;
`else
    assign best_time = '1;
`endif

endmodule

// File: tb/tb_lights_reaction_timer.sv
// Randomized bench for lights_reaction_timer against an elapsed-cycle model.
// Two instances share stimulus: (TICK_DIV=4, COUNT_W=16) and (2, 4).
module tb_lights_reaction_timer;

`ifdef LIGHTS_BEST_TIME_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_SEQ = 1, M_FULL = 2;
    localparam int M_TIMING = 3, M_DONE = 4, M_FAULT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  lights = 8'h00;
    logic        trigger = 1'b0;

    logic [15:0] time_a, best_a;
    logic        valid_a, fs_a, busy_a;
    logic [3:0]  time_b, best_b;
    logic        valid_b, fs_b, busy_b;

    int n_vec = 0;
    int n_err = 0;

    int          mst;
    int          k;
    logic        e_valid, e_fs, e_busy;
    logic [15:0] e_ta, e_ba;
    logic [3:0]  e_tb, e_bb;

    always #5 clk = ~clk;

    lights_reaction_timer #(.TICK_DIV(4), .COUNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .lights(lights), .trigger(trigger),
        .time_out(time_a), .valid(valid_a), .false_start(fs_a),
        .busy(busy_a), .best_time(best_a)
    );

    lights_reaction_timer #(.TICK_DIV(2), .COUNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .lights(lights), .trigger(trigger),
        .time_out(time_b), .valid(valid_b), .false_start(fs_b),
        .busy(busy_b), .best_time(best_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ticks(input int cyc, input int div, input int mx);
        int t;
        t = cyc / div;
        return (t > mx) ? mx : t;
    endfunction

    task automatic model_reset();
        mst     = M_IDLE;
        k       = 0;
        e_valid = 1'b0;
        e_fs    = 1'b0;
        e_busy  = 1'b0;
        e_ta    = '0;
        e_tb    = '0;
        e_ba    = '1;
        e_bb    = '1;
    endtask

    task automatic model_edge(input logic [7:0] l, input logic t);
        e_valid = 1'b0;
        case (mst)
            M_IDLE:   if (l != 0) mst = t ? M_FAULT : M_SEQ;
            M_SEQ: begin
                if (t)              mst = M_FAULT;
                else if (l == 8'hFF) mst = M_FULL;
                else if (l == 0)    mst = M_IDLE;
            end
            M_FULL: begin
                if (t) mst = M_FAULT;
                else if (l == 0) begin
                    mst = M_TIMING;
                    k   = 0;
                end
            end
            M_TIMING: begin
                k++;
                if (t) begin
                    e_ta    = 16'(ticks(k, 4, 65535));
                    e_tb    = 4'(ticks(k, 2, 15));
                    e_valid = 1'b1;
                    if (BEST_EN && e_ta < e_ba) e_ba = e_ta;
                    if (BEST_EN && e_tb < e_bb) e_bb = e_tb;
                    mst = M_DONE;
                end else if (l != 0) begin
                    mst = M_SEQ;
                end
            end
            M_DONE:  if (!t) mst = M_IDLE;
            M_FAULT: if (l == 0 && !t) mst = M_IDLE;
            default: mst = M_IDLE;
        endcase
        e_busy = (mst == M_SEQ) || (mst == M_FULL) || (mst == M_TIMING);
        e_fs   = (mst == M_FAULT);
    endtask

    task automatic check_all();
        chk("valid_a", 32'(valid_a), 32'(e_valid));
        chk("time_a",  32'(time_a),  32'(e_ta));
        chk("fs_a",    32'(fs_a),    32'(e_fs));
        chk("busy_a",  32'(busy_a),  32'(e_busy));
        chk("best_a",  32'(best_a),  32'(e_ba));
        chk("valid_b", 32'(valid_b), 32'(e_valid));
        chk("time_b",  32'(time_b),  32'(e_tb));
        chk("fs_b",    32'(fs_b),    32'(e_fs));
        chk("busy_b",  32'(busy_b),  32'(e_busy));
        chk("best_b",  32'(best_b),  32'(e_bb));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(lights, trigger);
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic seq_up(input logic [7:0] upto);
        lights = 8'h01;
        forever begin
            steps($urandom_range(1, 2));
            if (lights == upto) break;
            lights = {lights[6:0], 1'b1};
        end
    endtask

    // k = delay: trigger is sampled delay edges after the lights-out edge.
    task automatic normal_run(input int delay, input int hold);
        trigger = 1'b0;
        seq_up(8'hFF);
        lights = 8'h00;
        step();
        steps(delay - 1);
        trigger = 1'b1;
        step();
        steps(hold);
        trigger = 1'b0;
        steps(2);
    endtask

    task automatic idle_steps(input int n);
        lights  = 8'h00;
        trigger = 1'b0;
        steps(n);
    endtask

    task automatic do_reset();
        lights  = 8'h00;
        trigger = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_time", 32'(time_a), 32'd0);
        chk("rst_best", 32'(best_a), 32'hFFFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        steps(3);
    endtask

    task automatic random_scenario();
        int kind;
        logic [7:0] lv;
        kind = $urandom_range(0, 5);
        lv   = 8'((1 << $urandom_range(1, 7)) - 1);
        case (kind)
            0: normal_run($urandom_range(1, 60), $urandom_range(0, 3));
            1: begin
                seq_up(lv);
                trigger = 1'b1;
                steps($urandom_range(1, 4));
                lights = 8'h00;
                steps($urandom_range(0, 2));
                idle_steps(2);
            end
            2: begin
                seq_up(lv);
                idle_steps($urandom_range(1, 3));
            end
            3: begin
                seq_up(8'hFF);
                lights  = 8'h00;
                trigger = 1'b1;
                step();
                idle_steps(2);
            end
            4: begin
                seq_up(8'hFF);
                lights = 8'h00;
                steps($urandom_range(1, 12));
                normal_run($urandom_range(1, 30), 0);
            end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    lights  = ($urandom_range(0, 2) == 0) ? 8'h00 :
                              8'($urandom_range(0, 255));
                    trigger = 1'($urandom_range(0, 1));
                    step();
                end
                idle_steps(3);
            end
        endcase
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        steps(3);

        normal_run(14, 2);
        chk("norm_time", 32'(time_a), 32'd3);

        trigger = 1'b0;
        seq_up(8'h07);
        trigger = 1'b1;
        step();
        chk("fs_set", 32'(fs_a), 32'd1);
        chk("fs_time", 32'(time_a), 32'd3);
        lights  = 8'h00;
        trigger = 1'b0;
        step();
        chk("fs_clr", 32'(fs_a), 32'd0);
        steps(2);

        seq_up(8'hFF);
        lights  = 8'h00;
        trigger = 1'b1;
        step();
        chk("sim_fs", 32'(fs_a), 32'd1);
        chk("sim_valid", 32'(valid_a), 32'd0);
        idle_steps(2);

        normal_run(40, 0);
        chk("sat_b", 32'(time_b), 32'd15);
        chk("sat_a", 32'(time_a), 32'd10);

        trigger = 1'b0;
        seq_up(8'hFF);
        lights = 8'h00;
        steps(7);
        do_reset();

        normal_run(36, 1);
        chk("best_9", 32'(best_a), BEST_EN ? 32'd9 : 32'hFFFF);
        normal_run(20, 0);
        chk("best_5", 32'(best_a), BEST_EN ? 32'd5 : 32'hFFFF);
        normal_run(28, 0);
        chk("best_5b", 32'(best_a), BEST_EN ? 32'd5 : 32'hFFFF);
        chk("time_7", 32'(time_a), 32'd7);

        for (int s = 0; s < 150; s++) random_scenario();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
